register_write_dispatcher: RTL and testbench
============================================

# register_write_dispatcher

Parametrised successor to the synth top-level's inline register-write decode. Sits between the `spi` block's register-write outputs and the voice pipeline stages. Edge-detects the SPI write strobe and buffers writes in a FIFO. Decodes each write into one-hot per-parameter strobes, a voice-operator address, sine-table and global-register writes. Optionally holds writes until a frame boundary so that parameter changes land together.

## Interface
Parameters:
- `VOICE_BITS`, default 5: voice-number width; 32 voices.
- `OPERATOR_BITS`, default 3: operator-number width; 8 operators. Requires `VOICE_BITS+OPERATOR_BITS <= 8`.
- `NUM_PARAMS`, default 19: number of voice-operator parameter codes, `6'h00..NUM_PARAMS-1`.
- `FIFO_DEPTH`, default 8: buffered writes, power of two, at least 2.

Ports:
- `i_Clock` in 1: single clock.
- `i_Reset` in 1: synchronous, active-high.
- `i_WriteEnable` in 1: level strobe from `spi`.
- `i_WriteNumber` in 16: register number.
- `i_WriteValue` in 16: register value.
- `i_FrameStart` in 1: one-cycle pulse when the voice-operator counter wraps to 0.
- `o_ParamWriteEnable` out NUM_PARAMS: one-hot strobe, indexed by parameter code.
- `o_ConfigWriteAddr` out VOICE_BITS+OPERATOR_BITS: `{voice, operator}`.
- `o_ConfigWriteData` out 16: write value, shared by all outputs.
- `o_SineTableWriteEnable` out 1: sine-table write strobe.
- `o_SineTableWriteAddress` out 14: sine-table address.
- `o_GlobalWriteEnable` out 1: global-register write strobe.
- `o_GlobalWriteAddress` out 14: global-register address.
- `o_Level` out $clog2(FIFO_DEPTH)+1: FIFO occupancy.
- `o_Overflow` out 1: sticky; a write was dropped because the FIFO was full.
- `o_DecodeError` out 1: sticky; a write was discarded as undecodable.

## Operation
- Edge detect: a write is captured only in a cycle with `i_WriteEnable=1` and `r_WriteEnableLast=0`.
  - `r_WriteEnableLast` resets to 1, so a strobe held high through reset is not replayed.
- Push: the captured `{number, value}` is pushed if `o_Level < FIFO_DEPTH` or a pop occurs in the same cycle. Otherwise it is dropped and `o_Overflow` is set.
- Pop: in free-running mode (see Configuration), one entry is popped per cycle while the FIFO is non-empty.
- Decode of a popped entry, by `n = WriteNumber`:
  - `n[15:14]=2'b11`: sine-table write, address `n[13:0]`.
  - `n[15:14]=2'b10`: global write, address `n[13:0]`.
  - `n[15:14]=2'b00`: voice-operator write.
    - Parameter code `p = n[13:8]`.
    - Operator = `n[OPERATOR_BITS-1:0]`, voice = next `VOICE_BITS` bits.
    - Discarded with `o_DecodeError` set if `p >= NUM_PARAMS`, or if any bit of `n[7:VOICE_BITS+OPERATOR_BITS]` is nonzero.
  - `n[15:14]=2'b01`: reserved; discarded, `o_DecodeError` set.
- Strobes:
  - At most one strobe output is high in any cycle, for exactly one cycle.
  - The address and data outputs are registered alongside the strobe.
  - The address and data outputs keep their last values when no strobe is high.
- Order: writes issue strictly in arrival order. There is no merging or coalescing.
- Sticky flags clear only on reset.
- Reset values: all strobes 0, all address and data outputs 0, `o_Level` 0, both sticky flags 0, FIFO empty.
- Reset mid-operation: all queued writes are lost and the frame-sync budget is cleared.

## Timing
- Latency, free-running mode with an empty FIFO:
  - Edge seen in cycle N.
  - Entry enqueued at the end of N; `o_Level=1` in N+1.
  - Entry popped and decoded in N+1.
  - Strobe high in N+2.
- Throughput: one write per cycle. SPI writes are much slower, so the FIFO absorbs only frame-sync holding.
- Simultaneous push and pop: `o_Level` is unchanged.
- Full FIFO with a pop in the same cycle: the push is accepted.
- Pointers wrap modulo FIFO_DEPTH.

## Configuration
- Macro: `DISPATCH_FRAME_SYNC_EN`.
- Undefined: free-running mode; `i_FrameStart` is ignored.
- Defined: pops are gated by a budget counter.
  - In the `i_FrameStart` cycle, budget := current `o_Level`. This excludes any push in that cycle.
  - A pop is allowed in any cycle where the budget is nonzero. This includes the `i_FrameStart` cycle itself, counting the freshly loaded value.
  - Each pop decrements the budget.
  - Writes arriving after `i_FrameStart` wait for the next frame.
  - An `i_FrameStart` during an active drain reloads the budget with the current occupancy.

## Test plan
- Voice-operator write, free-running: rising edge with number `16'h0213`, value `16'hABCD`.
  - Two cycles later: `o_ParamWriteEnable=1<<2` for one cycle, `o_ConfigWriteAddr=8'h13`, data `16'hABCD`.
- Strobe held high 10 cycles, then through reset:
  - Exactly one strobe results.
  - After reset deasserts with `i_WriteEnable` still high, no strobe occurs.
- Sine-table and global writes:
  - `16'hC123` gives `o_SineTableWriteEnable` with address `14'h0123`.
  - `16'h8005` gives `o_GlobalWriteEnable` with address 5.
- Decode errors, NUM_PARAMS=19:
  - Number `16'h1300` gives no strobe and `o_DecodeError=1`.
  - With VOICE_BITS=4, OPERATOR_BITS=3, number `16'h0080` also gives no strobe and sets `o_DecodeError`.
- Overflow, frame-sync build, depth 8:
  - 9 writes with no `i_FrameStart` gives `o_Level=8` and `o_Overflow=1`.
  - Pulse `i_FrameStart`: 8 strobes in consecutive cycles, in order.
  - The 9th write never issues.
- Frame-sync drain with a late write:
  - Queue 3 writes, pulse `i_FrameStart`, push a 4th in that same cycle: exactly 3 strobes.
  - The 4th issues only after the next `i_FrameStart`.

Source files
------------

// File: rtl/register_write_dispatcher.sv
// register_write_dispatcher
//   Turns the SPI block's level write strobe into single-cycle, one-hot
//   register-write strobes for the voice pipeline. Writes pass through a small
//   FIFO and are decoded into four classes:
//     - voice-operator parameter writes
//     - sine-table writes
//     - global-register writes
//     - discards for reserved or undecodable numbers
//   Optional build macro DISPATCH_FRAME_SYNC_EN holds queued writes until
//   i_FrameStart, so that a frame's parameter changes land together.
module register_write_dispatcher #(
  parameter int VOICE_BITS    = 5,
  parameter int OPERATOR_BITS = 3,
  parameter int NUM_PARAMS    = 19,
  parameter int FIFO_DEPTH    = 8
) (
  input  logic                                i_Clock,
  input  logic                                i_Reset,
  input  logic                                i_WriteEnable,
  input  logic [15:0]                         i_WriteNumber,
  input  logic [15:0]                         i_WriteValue,
  input  logic                                i_FrameStart,
  output logic [NUM_PARAMS-1:0]               o_ParamWriteEnable,
  output logic [VOICE_BITS+OPERATOR_BITS-1:0] o_ConfigWriteAddr,
  output logic [15:0]                         o_ConfigWriteData,
  output logic                                o_SineTableWriteEnable,
  output logic [13:0]                         o_SineTableWriteAddress,
  output logic                                o_GlobalWriteEnable,
  output logic [13:0]                         o_GlobalWriteAddress,
  output logic [$clog2(FIFO_DEPTH):0]         o_Level,
  output logic                                o_Overflow,
  output logic                                o_DecodeError
);

  localparam int ADDR_W  = VOICE_BITS + OPERATOR_BITS;
  localparam int PTR_W   = $clog2(FIFO_DEPTH);
  localparam int LEVEL_W = PTR_W + 1;

  localparam logic [LEVEL_W-1:0] FULL_LEVEL  = LEVEL_W'(FIFO_DEPTH);
  localparam logic [6:0]         PARAM_LIMIT = 7'(NUM_PARAMS);

  // Top two bits of the register number select the target region.
  localparam logic [1:0] REGION_VOICE    = 2'b00;
  localparam logic [1:0] REGION_RESERVED = 2'b01;
  localparam logic [1:0] REGION_GLOBAL   = 2'b10;
  localparam logic [1:0] REGION_SINE     = 2'b11;

  // Strobe edge detector and FIFO bookkeeping.
  logic               we_last_q, we_last_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [LEVEL_W-1:0] level_q, level_d;
  logic               overflow_q, overflow_d;
  logic               decode_error_q, decode_error_d;
  logic [31:0]        fifo_mem [FIFO_DEPTH];

  logic capture;
  logic push;
  logic pop;

  // Registered strobe, address and data outputs.
  logic [NUM_PARAMS-1:0] param_we_q, param_we_d;
  logic [ADDR_W-1:0]     cfg_addr_q, cfg_addr_d;
  logic [15:0]           data_q, data_d;
  logic                  sine_we_q, sine_we_d;
  logic [13:0]           sine_addr_q, sine_addr_d;
  logic                  glob_we_q, glob_we_d;
  logic [13:0]           glob_addr_q, glob_addr_d;

  // Popped entry fields.
  logic [31:0] head;
  logic [15:0] head_num;
  logic [15:0] head_val;
  logic [5:0]  head_param;
  logic        voice_fields_ok;

`ifdef DISPATCH_FRAME_SYNC_EN
  logic [LEVEL_W-1:0] budget_q, budget_d;
  logic [LEVEL_W-1:0] budget_eff;
`else
  logic unused_frame_start;
  assign unused_frame_start = i_FrameStart;
`endif

  // Edge detect, push/pop arbitration, occupancy and the sticky overflow flag.
  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path can leave it unassigned and infer a latch.
    capture    = i_WriteEnable & ~we_last_q;
    we_last_d  = i_WriteEnable;

`ifdef DISPATCH_FRAME_SYNC_EN
    // A frame start snapshots the occupancy before this cycle's push, so
    // late arrivals wait for the following frame.
    budget_eff = i_FrameStart ? level_q : budget_q;
    pop        = (budget_eff != '0) && (level_q != '0);
    budget_d   = budget_eff - LEVEL_W'(pop);
`else
    pop        = (level_q != '0);
`endif

    push       = capture & ((level_q != FULL_LEVEL) | pop);
    overflow_d = overflow_q | (capture & ~push);
    wr_ptr_d   = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d   = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    level_d    = level_q + LEVEL_W'(push) - LEVEL_W'(pop);
  end

  assign head       = fifo_mem[rd_ptr_q];
  assign head_num   = head[31:16];
  assign head_val   = head[15:0];
  assign head_param = head_num[13:8];

  // Voice and operator fields must fit in ADDR_W bits, and the parameter code
  // must name an existing parameter.
  assign voice_fields_ok = ((head_num[7:0] >> ADDR_W) == 8'd0) &&
                           ({1'b0, head_param} < PARAM_LIMIT);

  // Decode the popped entry into next-cycle strobes; addresses and data hold when idle.
  always_comb begin
    param_we_d     = '0;
    sine_we_d      = 1'b0;
    glob_we_d      = 1'b0;
    cfg_addr_d     = cfg_addr_q;
    data_d         = data_q;
    sine_addr_d    = sine_addr_q;
    glob_addr_d    = glob_addr_q;
    decode_error_d = decode_error_q;

    if (pop) begin
      case (head_num[15:14])
        REGION_SINE: begin
          sine_we_d   = 1'b1;
          sine_addr_d = head_num[13:0];
          data_d      = head_val;
        end
        REGION_GLOBAL: begin
          glob_we_d   = 1'b1;
          glob_addr_d = head_num[13:0];
          data_d      = head_val;
        end
        REGION_VOICE: begin
          if (voice_fields_ok) begin
            for (int i = 0; i < NUM_PARAMS; i++) begin
              param_we_d[i] = (head_param == 6'(i));
            end
            cfg_addr_d = head_num[ADDR_W-1:0];
            data_d     = head_val;
          end else begin
            decode_error_d = 1'b1;
          end
        end
        REGION_RESERVED: decode_error_d = 1'b1;
        default:         decode_error_d = 1'b1;
      endcase
    end
  end

  // FIFO storage: written on push only.
  always_ff @(posedge i_Clock) begin
    // NOTE: the storage array has no reset; the pointers and level define which entries are valid, and leaving it unreset keeps it mappable to RAM.
    if (push) begin
      fifo_mem[wr_ptr_q] <= {i_WriteNumber, i_WriteValue};
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge i_Clock) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples the pre-edge values.
    if (i_Reset) begin
      // Start high so a strobe held through reset is not treated as a new write.
      we_last_q      <= 1'b1;
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      level_q        <= '0;
      overflow_q     <= 1'b0;
      decode_error_q <= 1'b0;
      param_we_q     <= '0;
      cfg_addr_q     <= '0;
      data_q         <= '0;
      sine_we_q      <= 1'b0;
      sine_addr_q    <= '0;
      glob_we_q      <= 1'b0;
      glob_addr_q    <= '0;
`ifdef DISPATCH_FRAME_SYNC_EN
      budget_q       <= '0;
`endif
    end else begin
      we_last_q      <= we_last_d;
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      level_q        <= level_d;
      overflow_q     <= overflow_d;
      decode_error_q <= decode_error_d;
      param_we_q     <= param_we_d;
      cfg_addr_q     <= cfg_addr_d;
      data_q         <= data_d;
      sine_we_q      <= sine_we_d;
      sine_addr_q    <= sine_addr_d;
      glob_we_q      <= glob_we_d;
      glob_addr_q    <= glob_addr_d;
`ifdef DISPATCH_FRAME_SYNC_EN
      budget_q       <= budget_d;
`endif
    end
  end

  assign o_ParamWriteEnable      = param_we_q;
  assign o_ConfigWriteAddr       = cfg_addr_q;
  assign o_ConfigWriteData       = data_q;
  assign o_SineTableWriteEnable  = sine_we_q;
  assign o_SineTableWriteAddress = sine_addr_q;
  assign o_GlobalWriteEnable     = glob_we_q;
  assign o_GlobalWriteAddress    = glob_addr_q;
  assign o_Level                 = level_q;
  assign o_Overflow              = overflow_q;
  assign o_DecodeError           = decode_error_q;

endmodule

// File: tb/tb_register_write_dispatcher.sv
// Testbench for register_write_dispatcher.
//   Uses VOICE_BITS=4 so the unused voice/operator bits of a voice write can be
//   exercised. Expected outputs come from a queue-based reference model.
//   Free-running tests run in the default build; frame-sync tests run when
//   DISPATCH_FRAME_SYNC_EN is defined.
module tb_register_write_dispatcher;

  localparam int VB = 4;
  localparam int OB = 3;
  localparam int NP = 19;
  localparam int FD = 8;
  localparam int AW = VB + OB;
  localparam int LW = $clog2(FD) + 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          we;
  logic [15:0]   wnum;
  logic [15:0]   wval;
  logic          fs;
  logic [NP-1:0] param_we;
  logic [AW-1:0] cfg_addr;
  logic [15:0]   cfg_data;
  logic          sine_we;
  logic [13:0]   sine_addr;
  logic          glob_we;
  logic [13:0]   glob_addr;
  logic [LW-1:0] level;
  logic          overflow;
  logic          dec_err;

  int assert_count = 0;
  int fail_count   = 0;

  always #5 clk = ~clk;

  register_write_dispatcher #(
    .VOICE_BITS(VB), .OPERATOR_BITS(OB), .NUM_PARAMS(NP), .FIFO_DEPTH(FD)
  ) dut (
    .i_Clock                 (clk),
    .i_Reset                 (rst),
    .i_WriteEnable           (we),
    .i_WriteNumber           (wnum),
    .i_WriteValue            (wval),
    .i_FrameStart            (fs),
    .o_ParamWriteEnable      (param_we),
    .o_ConfigWriteAddr       (cfg_addr),
    .o_ConfigWriteData       (cfg_data),
    .o_SineTableWriteEnable  (sine_we),
    .o_SineTableWriteAddress (sine_addr),
    .o_GlobalWriteEnable     (glob_we),
    .o_GlobalWriteAddress    (glob_addr),
    .o_Level                 (level),
    .o_Overflow              (overflow),
    .o_DecodeError           (dec_err)
  );

  // Reference model: pending writes plus the outputs they should produce.
  logic [31:0]   model_q[$];
  logic [NP-1:0] exp_param;
  logic [AW-1:0] exp_cfg_addr;
  logic [15:0]   exp_data;
  logic          exp_sine;
  logic [13:0]   exp_sine_addr;
  logic          exp_glob;
  logic [13:0]   exp_glob_addr;
  logic          exp_ovf;
  logic          exp_err;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    assert_count++;
    assert (obs === exp) else begin
      fail_count++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    model_q.delete();
    exp_param     = '0;
    exp_cfg_addr  = '0;
    exp_data      = '0;
    exp_sine      = 1'b0;
    exp_sine_addr = '0;
    exp_glob      = 1'b0;
    exp_glob_addr = '0;
    exp_ovf       = 1'b0;
    exp_err       = 1'b0;
  endtask

  task automatic model_idle();
    exp_param = '0;
    exp_sine  = 1'b0;
    exp_glob  = 1'b0;
  endtask

  task automatic model_push(input logic [15:0] num, input logic [15:0] val);
    if (model_q.size() < FD) model_q.push_back({num, val});
    else exp_ovf = 1'b1;
  endtask

  // Issue the oldest pending write using plain arithmetic on the register number.
  task automatic model_pop_issue();
    logic [31:0] entry;
    int unsigned n, kind, p, low;
    model_idle();
    entry = model_q.pop_front();
    n     = entry[31:16];
    kind  = n / 16384;
    p     = (n / 256) % 64;
    low   = n % 256;
    case (kind)
      3: begin exp_sine = 1'b1; exp_sine_addr = 14'(n % 16384); exp_data = entry[15:0]; end
      2: begin exp_glob = 1'b1; exp_glob_addr = 14'(n % 16384); exp_data = entry[15:0]; end
      0: begin
        if (p < NP && low < (1 << AW)) begin
          exp_param[p] = 1'b1;
          exp_cfg_addr = AW'(low);
          exp_data     = entry[15:0];
        end else begin
          exp_err = 1'b1;
        end
      end
      default: exp_err = 1'b1;
    endcase
  endtask

  task automatic check_outputs(input string tag);
    check({tag, " param_we"},  64'(param_we),  64'(exp_param));
    check({tag, " cfg_addr"},  64'(cfg_addr),  64'(exp_cfg_addr));
    check({tag, " data"},      64'(cfg_data),  64'(exp_data));
    check({tag, " sine_we"},   64'(sine_we),   64'(exp_sine));
    check({tag, " sine_addr"}, 64'(sine_addr), 64'(exp_sine_addr));
    check({tag, " glob_we"},   64'(glob_we),   64'(exp_glob));
    check({tag, " glob_addr"}, 64'(glob_addr), 64'(exp_glob_addr));
    check({tag, " level"},     64'(level),     64'(model_q.size()));
    check({tag, " overflow"},  64'(overflow),  64'(exp_ovf));
    check({tag, " dec_err"},   64'(dec_err),   64'(exp_err));
  endtask

  // Free-running write: checks enqueue cycle, strobe cycle and return to idle.
  task automatic write_check(input logic [15:0] num, input logic [15:0] val, input string tag);
    @(negedge clk);
    we = 1'b1; wnum = num; wval = val;
    @(negedge clk);
    we = 1'b0;
    model_push(num, val);
    model_idle();
    check_outputs({tag, "@N+1"});
    @(negedge clk);
    model_pop_issue();
    check_outputs({tag, "@N+2"});
    @(negedge clk);
    model_idle();
    check_outputs({tag, "@N+3"});
  endtask

  // Frame-sync write: queued only, no strobe expected.
  task automatic fs_send(input logic [15:0] num, input logic [15:0] val, input string tag);
    @(negedge clk);
    we = 1'b1; wnum = num; wval = val;
    @(negedge clk);
    we = 1'b0;
    model_push(num, val);
    model_idle();
    check_outputs(tag);
  endtask

  function automatic logic [15:0] rand_number();
    int unsigned kind;
    kind = $urandom_range(0, 3);
    if (kind == 0) return 16'(($urandom_range(0, 21) << 8) | $urandom_range(0, 255));
    return 16'((kind << 14) | $urandom_range(0, 16383));
  endfunction

  initial begin
    int strobes;
    rst = 1'b1; we = 1'b0; wnum = '0; wval = '0; fs = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_outputs("reset");

`ifndef DISPATCH_FRAME_SYNC_EN
    // Directed decode cases.
    write_check(16'h0213, 16'hABCD, "voice_op");
    write_check(16'hC123, 16'h5A5A, "sine");
    write_check(16'h8005, 16'h1234, "global");
    write_check(16'h1300, 16'h0F0F, "bad_param");
    write_check(16'h0080, 16'hF0F0, "bad_voice");
    write_check(16'h4001, 16'h7777, "reserved");
    write_check(16'h1277, 16'h2222, "last_param");

    // Randomized writes against the model.
    for (int i = 0; i < 30; i++) begin
      write_check(rand_number(), 16'($urandom), "rand");
    end

    // Held strobe yields one write; holding it through reset yields none.
    @(negedge clk);
    we = 1'b1; wnum = 16'h0213; wval = 16'h1111;
    strobes = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (|param_we || sine_we || glob_we) strobes++;
    end
    check("held_strobe_count", 64'(strobes), 64'd1);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    model_reset();
    check_outputs("held_reset");
    strobes = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (|param_we || sine_we || glob_we) strobes++;
    end
    check("held_after_reset_count", 64'(strobes), 64'd0);
    check_outputs("held_after_reset");
    we = 1'b0;
`else
    // Overflow: nine writes without a frame start.
    for (int i = 0; i < 9; i++) begin
      fs_send(16'((i << 8) | i), 16'($urandom), "fill");
    end
    @(negedge clk);
    fs = 1'b1;
    @(negedge clk);
    fs = 1'b0;
    for (int k = 0; k < 8; k++) begin
      model_pop_issue();
      check_outputs("drain");
      @(negedge clk);
    end
    model_idle();
    for (int i = 0; i < 3; i++) begin
      check_outputs("drain_idle");
      @(negedge clk);
    end

    // Late write in the frame-start cycle waits for the next frame.
    for (int i = 0; i < 3; i++) begin
      fs_send(rand_number(), 16'($urandom), "late_fill");
    end
    @(negedge clk);
    fs = 1'b1; we = 1'b1; wnum = 16'hC3C3; wval = 16'hBEEF;
    @(negedge clk);
    fs = 1'b0; we = 1'b0;
    model_pop_issue();
    model_push(16'hC3C3, 16'hBEEF);
    check_outputs("late_drain0");
    for (int k = 1; k < 3; k++) begin
      @(negedge clk);
      model_pop_issue();
      check_outputs("late_drain");
    end
    model_idle();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_outputs("late_wait");
    end
    @(negedge clk);
    fs = 1'b1;
    @(negedge clk);
    fs = 1'b0;
    model_pop_issue();
    check_outputs("late_issue");
    @(negedge clk);
    model_idle();
    check_outputs("late_done");
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
    $finish;
  end

endmodule
